// File: rtl/mac_r.sv
// mac_r: MII receive MAC for one switch port.
// rx_clk side strips preamble/SFD, assembles bytes, checks CRC-32 and length,
// and pushes bytes plus one status word per frame into two async FIFOs.
// clk side pops one frame at a time and forwards it to the switch ingress.
// Handshakes are strobe-only: a write strobe is valid for exactly one clk
// cycle and the receiver must accept it; bp only stops the start of new frames.

module async_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  wrstn,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH:0]   wfree,
    input  logic                  rclk,
    input  logic                  rrstn,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH:0]   wbin, wgray, rbin, rgray;
    logic [ADDR_WIDTH:0]   rgray_s1, rgray_s2, wgray_s1, wgray_s2;
    logic [ADDR_WIDTH:0]   wbin_nxt, rbin_nxt, rbin_w;
    logic                  do_wr, do_rd;

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign wbin_nxt = wbin + 1'b1;
    assign rbin_nxt = rbin + 1'b1;
    assign rbin_w   = gray2bin(rgray_s2);
    assign wfree    = DEPTH_W - (wbin - rbin_w);
    assign rempty   = (rgray == wgray_s2);
    assign do_wr    = wr && (wfree != '0);
    assign do_rd    = rd && !rempty;

    // Storage write; memory has no reset, pointers define validity.
    always_ff @(posedge wclk) begin
        if (do_wr) mem[wbin[ADDR_WIDTH-1:0]] <= wdata;
    end

    // Write pointer and read-pointer synchronizer in the write domain.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wbin     <= '0;
            wgray    <= '0;
            rgray_s1 <= '0;
            rgray_s2 <= '0;
        end else begin
            rgray_s1 <= rgray;
            rgray_s2 <= rgray_s1;
            if (do_wr) begin
                wbin  <= wbin_nxt;
                wgray <= wbin_nxt ^ (wbin_nxt >> 1);
            end
        end
    end

    // Read pointer, registered read data and write-pointer synchronizer.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            rbin     <= '0;
            rgray    <= '0;
            rdata    <= '0;
            wgray_s1 <= '0;
            wgray_s2 <= '0;
        end else begin
            wgray_s1 <= wgray;
            wgray_s2 <= wgray_s1;
            if (do_rd) begin
                rdata <= mem[rbin[ADDR_WIDTH-1:0]];
                rbin  <= rbin_nxt;
                rgray <= rbin_nxt ^ (rbin_nxt >> 1);
            end
        end
    end
endmodule

module mac_r #(
    parameter int DELAY    = 2,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518,
    parameter int DROP_BAD = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_clk,
    input  logic        rx_dv,
    input  logic [3:0]  rx_d,
    input  logic        bp,
    output logic        data_fifo_wr,
    output logic [7:0]  data_fifo_dout,
    output logic        ptr_fifo_wr,
    output logic [15:0] ptr_fifo_dout,
    output logic [15:0] err_cnt
);
    // DELAY only matters to delay-annotated simulation models; the RTL has none.
    if (DELAY < 0) begin : g_delay_range
    end

    localparam logic [10:0] MAX_W = 11'(MAX_LEN);
    localparam logic [10:0] MIN_W = 11'(MIN_LEN);

    // Ethernet CRC-32, MSB-first register, data bits fed LSB first.
    function automatic logic [31:0] crc32_8023(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[31] ^ d[i]) ? ({r[30:0], 1'b0} ^ 32'h04C11DB7) : {r[30:0], 1'b0};
        return r;
    endfunction

    // ---------------- rx_clk domain ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_SKIP} rx_state_t;
    rx_state_t   rx_state, rx_next;
    logic        phase;
    logic [3:0]  lo_nib;
    logic [10:0] rx_len;
    logic [31:0] crc_reg;
    logic        dwr_q, swr_q;
    logic [7:0]  dbyte_q;
    logic [15:0] sword_q;
    logic [12:0] d_free;
    logic [5:0]  s_free;
    logic        space_ok, sfd_hit, nib_hit, eof_hit;
    logic        crc_bad, len_bad;
    logic [10:0] len_field;
    logic [7:0]  rx_byte;

    assign rx_byte   = {rx_d, lo_nib};
    assign space_ok  = (d_free >= 13'(MAX_LEN)) && (s_free != 6'd0);
    assign crc_bad   = (crc_reg != 32'hC704DD7B);
    assign len_bad   = (rx_len < MIN_W) || (rx_len > MAX_W) || phase;
    assign len_field = (rx_len > MAX_W) ? MAX_W : rx_len;

    // rx FSM state register.
    always_ff @(posedge rx_clk or negedge rstn) begin
        if (!rstn) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // rx FSM next state: hunt preamble, check space at SFD, receive, or skip.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_dv) rx_next = (rx_d == 4'h5) ? RX_PRE : RX_SKIP;
            RX_PRE: begin
                if (!rx_dv)              rx_next = RX_IDLE;
                else if (rx_d == 4'h5)   rx_next = RX_PRE;
                else if (rx_d == 4'hD)   rx_next = space_ok ? RX_DATA : RX_SKIP;
                else                     rx_next = RX_IDLE;
            end
            RX_DATA: if (!rx_dv) rx_next = RX_IDLE;
            RX_SKIP: if (!rx_dv) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    // rx FSM outputs: SFD accepted, nibble received, end of frame.
    always_comb begin
        sfd_hit = 1'b0;
        nib_hit = 1'b0;
        eof_hit = 1'b0;
        if (rx_state == RX_PRE && rx_dv && rx_d == 4'hD && space_ok) sfd_hit = 1'b1;
        if (rx_state == RX_DATA) begin
            nib_hit = rx_dv;
            eof_hit = !rx_dv;
        end
    end

    // Byte assembly, CRC, length count and registered FIFO writes.
    always_ff @(posedge rx_clk or negedge rstn) begin
        if (!rstn) begin
            phase   <= 1'b0;
            lo_nib  <= '0;
            rx_len  <= '0;
            crc_reg <= '1;
            dwr_q   <= 1'b0;
            dbyte_q <= '0;
            swr_q   <= 1'b0;
            sword_q <= '0;
        end else begin
            dwr_q <= 1'b0;
            swr_q <= 1'b0;
            if (sfd_hit) begin
                phase   <= 1'b0;
                rx_len  <= '0;
                crc_reg <= '1;
            end else if (nib_hit) begin
                phase <= ~phase;
                if (!phase) begin
                    lo_nib <= rx_d;
                end else begin
                    crc_reg <= crc32_8023(crc_reg, rx_byte);
                    if (rx_len != 11'h7FF) rx_len <= rx_len + 11'd1;
                    if (rx_len < MAX_W) begin
                        dwr_q   <= 1'b1;
                        dbyte_q <= rx_byte;
                    end
                end
            end
            if (eof_hit) begin
                swr_q   <= 1'b1;
                sword_q <= {crc_bad, len_bad, 3'b000, len_field};
            end
        end
    end

    // ---------------- FIFOs ----------------
    logic        s_empty, d_empty, ptr_rd, dat_rd;
    logic [15:0] s_rdata;
    logic [7:0]  d_rdata;

    async_fifo #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) u_data_fifo (
        .wclk(rx_clk), .wrstn(rstn), .wr(dwr_q), .wdata(dbyte_q), .wfree(d_free),
        .rclk(clk), .rrstn(rstn), .rd(dat_rd), .rdata(d_rdata), .rempty(d_empty)
    );

    async_fifo #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) u_stat_fifo (
        .wclk(rx_clk), .wrstn(rstn), .wr(swr_q), .wdata(sword_q), .wfree(s_free),
        .rclk(clk), .rrstn(rstn), .rd(ptr_rd), .rdata(s_rdata), .rempty(s_empty)
    );

    // ---------------- clk domain ----------------
    typedef enum logic [2:0] {C_IDLE, C_WAIT, C_LOAD, C_RD, C_DONE} c_state_t;
    c_state_t    c_state, c_next;
    logic [15:0] stat_q;
    logic [10:0] cnt;
    logic [1:0]  rd_pipe;
    logic        fwd, done_q, drain_done;

    assign drain_done    = (rd_pipe == 2'b00);
    assign ptr_fifo_dout = stat_q;

    // clk FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) c_state <= C_IDLE;
        else       c_state <= c_next;
    end

    // clk FSM next state: pop status, read len bytes, drain, report.
    always_comb begin
        c_next = c_state;
        case (c_state)
            C_IDLE: if (!s_empty && !bp && !done_q) c_next = C_WAIT;
            C_WAIT: c_next = C_LOAD;
            C_LOAD: c_next = (s_rdata[10:0] == 11'd0) ? C_DONE : C_RD;
            C_RD:   if (dat_rd && cnt == 11'd1) c_next = C_DONE;
            C_DONE: if (drain_done) c_next = C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    // clk FSM outputs: FIFO reads and ingress strobes.
    always_comb begin
        ptr_rd       = 1'b0;
        dat_rd       = 1'b0;
        ptr_fifo_wr  = 1'b0;
        data_fifo_wr = rd_pipe[1] && fwd;
        case (c_state)
            C_IDLE: ptr_rd = !s_empty && !bp && !done_q;
            C_RD:   dat_rd = !d_empty;
            C_DONE: ptr_fifo_wr = drain_done && fwd;
            default: ;
        endcase
    end

    // clk datapath: status latch, byte countdown, strobe pipe, error counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_q         <= '0;
            cnt            <= '0;
            fwd            <= 1'b0;
            rd_pipe        <= '0;
            done_q         <= 1'b0;
            data_fifo_dout <= '0;
            err_cnt        <= '0;
        end else begin
            rd_pipe        <= {rd_pipe[0], dat_rd};
            data_fifo_dout <= d_rdata;
            done_q         <= (c_state == C_DONE) && drain_done;
            if (c_state == C_LOAD) begin
                stat_q <= s_rdata;
                cnt    <= s_rdata[10:0];
                fwd    <= !((DROP_BAD != 0) && (s_rdata[15] || s_rdata[14]));
            end else if (dat_rd) begin
                cnt <= cnt - 11'd1;
            end
            if (c_state == C_DONE && drain_done && (stat_q[15] || stat_q[14]) &&
                err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
endmodule
